flexible_and_arbiter: RTL and testbench

- Round-robin arbiter that shares one flexible AND datapath instance among NUM_REQ requesters.
- Accepts operand/control requests over valid/ready and drives the datapath's a/b/invert inputs from registers.
- Tracks each in-flight operation through the datapath's fixed pipeline latency and returns the result tagged with the requester ID.
- Sits between client blocks and the single flexible AND instance.

---
 rtl/flexible_and_arbiter.sv | 81 ++++++++
 tb/tb_flexible_and_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/flexible_and_arbiter.sv
// flexible_and_arbiter: round-robin front end sharing one pipelined flexible AND datapath
// among NUM_REQ requesters, returning each result tagged with its requester id.
module flexible_and_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DP_LATENCY = 2,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   input  logic [3*NUM_REQ-1:0]   req_inv,
   input  logic                   quiesce,
   output logic [7:0]             fa_a,
   output logic [7:0]             fa_b,
   output logic                   fa_invert_a,
   output logic                   fa_invert_b,
   output logic                   fa_invert_y,
   input  logic [7:0]             fa_y,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [7:0]             rsp_y,
   output logic                   idle
);
   localparam logic [ID_W:0] N = (ID_W+1)'(NUM_REQ);
   logic [ID_W-1:0] ptr, gid, nxt;
   logic [ID_W:0] idx;
   logic go;
   logic [7:0] sel_a, sel_b;
   logic [2:0] sel_inv;
   logic [DP_LATENCY:0] tag_v;
   logic [ID_W-1:0] tag_id [DP_LATENCY+1];
   // search from the pointer upward with wrap; reset also blocks grants
   always_comb begin
      go = 1'b0;
      gid = '0;
      idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + (ID_W+1)'(k);
         idx = idx >= N ? idx - N : idx;
         if (!go && !quiesce && !reset && req_valid[idx[ID_W-1:0]]) begin
            go = 1'b1;
            gid = idx[ID_W-1:0];
         end
      end
   end
   assign req_ready = go ? NUM_REQ'(1) << gid : '0;
   assign nxt = gid == ID_W'(NUM_REQ-1) ? '0 : gid + 1'b1;
   assign sel_a = req_a[8*gid +: 8];
   assign sel_b = req_b[8*gid +: 8];
   assign sel_inv = req_inv[3*gid +: 3];
   assign idle = ~|req_ready & ~|tag_v & ~rsp_valid;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr <= '0;
         fa_a <= '0;
         fa_b <= '0;
         {fa_invert_y, fa_invert_b, fa_invert_a} <= 3'b000;
         tag_v <= '0;
         tag_id <= '{default: '0};
         rsp_valid <= 1'b0;
         rsp_id <= '0;
         rsp_y <= '0;
      end else begin
         ptr <= go ? nxt : ptr;
         fa_a <= go ? sel_a : '0;
         fa_b <= go ? sel_b : '0;
         {fa_invert_y, fa_invert_b, fa_invert_a} <= go ? sel_inv : 3'b000;
         tag_v <= {tag_v[DP_LATENCY-1:0], go};
         tag_id[0] <= gid;
         for (int s = 1; s <= DP_LATENCY; s++) tag_id[s] <= tag_id[s-1];
         rsp_valid <= tag_v[DP_LATENCY];
         if (tag_v[DP_LATENCY]) begin
            rsp_y <= fa_y;
            rsp_id <= tag_id[DP_LATENCY];
         end
      end
   end
endmodule

// File: tb/tb_flexible_and_arbiter.sv
// tb_flexible_and_arbiter: directed scenarios against the arbiter with a two-stage
// flexible AND datapath model closing the loop from fa_* back to fa_y.
module tb_flexible_and_arbiter;
   logic clock, reset, quiesce;
   logic [3:0] req_valid, req_ready;
   logic [31:0] req_a, req_b;
   logic [11:0] req_inv;
   logic [7:0] fa_a, fa_b, fa_y, rsp_y, s1;
   logic fa_invert_a, fa_invert_b, fa_invert_y, rsp_valid, idle;
   logic [1:0] rsp_id;
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_y [4] = '{8'h0F, 8'h44, 8'hEF, 8'h00};

   flexible_and_arbiter dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_inv(req_inv), .quiesce(quiesce),
      .fa_a(fa_a), .fa_b(fa_b), .fa_invert_a(fa_invert_a), .fa_invert_b(fa_invert_b),
      .fa_invert_y(fa_invert_y), .fa_y(fa_y), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .idle(idle)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // external datapath: samples one edge after the drive, y two edges later
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         fa_y <= '0;
      end else begin
         s1 <= ((fa_invert_a ? ~fa_a : fa_a) & (fa_invert_b ? ~fa_b : fa_b)) ^ {8{fa_invert_y}};
         fa_y <= s1;
      end
   end

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 4'b1111;
      quiesce = 1'b0;
      req_a = '0;
      req_b = '0;
      req_inv = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         #1;
         checks++;
         if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
         checks++;
         if ({fa_a, fa_b, fa_invert_a, fa_invert_b, fa_invert_y} !== 19'd0) begin errors++; $display("FAIL reset_fa got %h/%h want 00/00", fa_a, fa_b); end
         checks++;
         if (rsp_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL reset_out got rsp_valid=%b idle=%b want 0/1", rsp_valid, idle); end
      end
      @(negedge clock);
      reset = 1'b0;
      req_valid = 4'b0000;
   endtask

   task automatic test_single_latency;
      for (int v = 0; v < 2; v++) begin
         logic [2:0] inv;
         logic [7:0] exp;
         inv = v == 1 ? 3'b101 : 3'b000;
         exp = v == 1 ? 8'hF3 : 8'h30;
         @(negedge clock);
         req_valid = 4'b0100;
         req_a[23:16] = 8'hF0;
         req_b[23:16] = 8'h3C;
         req_inv[8:6] = inv;
         #1;
         checks++;
         if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
         for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            req_valid = 4'b0000;
            #1;
            if (k == 1) begin
               checks++;
               if (fa_a !== 8'hF0 || fa_b !== 8'h3C || {fa_invert_y, fa_invert_b, fa_invert_a} !== inv)
                  begin errors++; $display("FAIL single_drive got %h %h %b want f0 3c %b", fa_a, fa_b, {fa_invert_y, fa_invert_b, fa_invert_a}, inv); end
            end
            if (k == 2) begin
               checks++;
               if (fa_a !== 8'h00 || fa_b !== 8'h00) begin errors++; $display("FAIL single_drive_idle got %h %h want 00 00", fa_a, fa_b); end
            end
            checks++;
            if (rsp_valid !== (k == 4)) begin errors++; $display("FAIL single_rsp_valid k=%0d got %b want %b", k, rsp_valid, k == 4); end
            if (k == 4) begin
               checks++;
               if (rsp_id !== 2'd2 || rsp_y !== exp) begin errors++; $display("FAIL single_rsp got id=%0d y=%h want id=2 y=%h", rsp_id, rsp_y, exp); end
            end
            if (k == 5) begin
               checks++;
               if (rsp_y !== exp) begin errors++; $display("FAIL single_hold got y=%h want %h", rsp_y, exp); end
            end
         end
      end
   endtask

   task automatic test_round_robin;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      req_a = {8'hF0, 8'h12, 8'hAA, 8'hFF};
      req_b = {8'hF0, 8'h34, 8'hCC, 8'h0F};
      req_inv = {3'b010, 3'b100, 3'b001, 3'b000};
      for (int c = 0; c <= 12; c++) begin
         logic [3:0] er;
         @(negedge clock);
         req_valid = c < 8 ? 4'b1111 : 4'b0000;
         er = c < 8 ? 4'b0001 << (c % 4) : 4'b0000;
         #1;
         checks++;
         if (req_ready !== er) begin errors++; $display("FAIL rr_ready c=%0d got %b want %b", c, req_ready, er); end
         checks++;
         if (rsp_valid !== (c >= 4 && c < 12)) begin errors++; $display("FAIL rr_rsp_valid c=%0d got %b", c, rsp_valid); end
         if (c >= 4 && c < 12) begin
            checks++;
            if (rsp_id !== 2'((c - 4) % 4) || rsp_y !== exp_y[(c - 4) % 4])
               begin errors++; $display("FAIL rr_rsp c=%0d got id=%0d y=%h want id=%0d y=%h", c, rsp_id, rsp_y, (c - 4) % 4, exp_y[(c - 4) % 4]); end
         end
      end
   endtask

   task automatic test_skip_wrap;
      logic [3:0] vs [9] = '{4'b0100, 4'b0011, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0] rs [9] = '{4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      int ids [4] = '{2, 0, 1, 3};
      for (int c = 0; c < 9; c++) begin
         @(negedge clock);
         req_valid = vs[c];
         #1;
         checks++;
         if (req_ready !== rs[c]) begin errors++; $display("FAIL skip_ready c=%0d got %b want %b", c, req_ready, rs[c]); end
         checks++;
         if (rsp_valid !== (c >= 4 && c < 8)) begin errors++; $display("FAIL skip_rsp_valid c=%0d got %b", c, rsp_valid); end
         if (c >= 4 && c < 8) begin
            checks++;
            if (rsp_id !== 2'(ids[c - 4]) || rsp_y !== exp_y[ids[c - 4]])
               begin errors++; $display("FAIL skip_rsp c=%0d got id=%0d y=%h want id=%0d y=%h", c, rsp_id, rsp_y, ids[c - 4], exp_y[ids[c - 4]]); end
         end
      end
   endtask

   task automatic test_quiesce;
      for (int c = 0; c < 10; c++) begin
         logic [3:0] er;
         @(negedge clock);
         req_valid = c < 3 ? 4'b0111 : 4'b1111;
         quiesce = c >= 3;
         er = c < 3 ? 4'b0001 << c : 4'b0000;
         #1;
         checks++;
         if (req_ready !== er) begin errors++; $display("FAIL quiesce_ready c=%0d got %b want %b", c, req_ready, er); end
         checks++;
         if (rsp_valid !== (c >= 4 && c < 7)) begin errors++; $display("FAIL quiesce_rsp_valid c=%0d got %b", c, rsp_valid); end
         if (c >= 4 && c < 7) begin
            checks++;
            if (rsp_id !== 2'(c - 4) || rsp_y !== exp_y[c - 4])
               begin errors++; $display("FAIL quiesce_rsp c=%0d got id=%0d y=%h want id=%0d y=%h", c, rsp_id, rsp_y, c - 4, exp_y[c - 4]); end
         end
         checks++;
         if (idle !== (c >= 7)) begin errors++; $display("FAIL quiesce_idle c=%0d got %b want %b", c, idle, c >= 7); end
      end
      @(negedge clock);
      quiesce = 1'b0;
      req_valid = 4'b0000;
   endtask

   task automatic test_reset_midflight;
      @(negedge clock);
      req_valid = 4'b1000;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready3 got %b want 1000", req_ready); end
      @(negedge clock);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ready0 got %b want 0001", req_ready); end
      @(negedge clock);
      req_valid = 4'b0000;
      reset = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || idle !== 1'b1 || fa_a !== 8'h00)
         begin errors++; $display("FAIL mid_in_reset got rsp_valid=%b idle=%b fa_a=%h want 0 1 00", rsp_valid, idle, fa_a); end
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         #1;
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_discard c=%0d got rsp_valid=%b want 0", c, rsp_valid); end
      end
      @(negedge clock);
      req_valid = 4'b1010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr got %b want 0010", req_ready); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         req_valid = 4'b0000;
         #1;
         checks++;
         if (rsp_valid !== (k == 4)) begin errors++; $display("FAIL mid_rsp_valid k=%0d got %b want %b", k, rsp_valid, k == 4); end
         if (k == 4) begin
            checks++;
            if (rsp_id !== 2'd1 || rsp_y !== 8'h44) begin errors++; $display("FAIL mid_rsp got id=%0d y=%h want id=1 y=44", rsp_id, rsp_y); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_latency;
      test_round_robin;
      test_skip_wrap;
      test_quiesce;
      test_reset_midflight;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
